// File: rtl/pcu_pkg.sv
// Shared definitions for the program counter unit: opcode encodings, FSM state type
// and the default address width.
package pcu_pkg;

    localparam int PCU_PC_W = 16;

    localparam logic [5:0] OP_LOAD   = 6'b000100;
    localparam logic [5:0] OP_STORE  = 6'b000101;
    localparam logic [5:0] OP_JMP    = 6'b000110;
    localparam logic [5:0] OP_BRANCH = 6'b000111;
    localparam logic [5:0] OP_CALL   = 6'b001000;
    localparam logic [5:0] OP_RET    = 6'b001001;
    localparam logic [5:0] OP_HALT   = 6'b111111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } pcu_state_t;

endpackage

// File: rtl/program_counter_unit_ras.sv
// Registered LIFO of return addresses. With WRAP_EN set it behaves as a circular
// buffer: a push when full overwrites the oldest entry and the count saturates.
module return_addr_stack
    import pcu_pkg::*;
#(
    parameter int PC_W    = PCU_PC_W,
    parameter int DEPTH   = 8,
    parameter bit WRAP_EN = 1'b0,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [PC_W-1:0]  push_data,
    output logic [PC_W-1:0]  top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PC_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // sp_q points at the next free slot, so the top sits one below it. When full and
    // wrapping, sp_q also points at the oldest entry, which is what gets overwritten.
    assign top   = mem_q[sp_q - PTR_ONE];

    always_comb begin
        mem_d   = mem_q;
        sp_d    = sp_q;
        count_d = count_q;
        if (push && !pop) begin
            if (!full || WRAP_EN) begin
                mem_d[sp_q] = push_data;
                sp_d        = sp_q + PTR_ONE;
                if (!full) begin
                    count_d = count_q + CNT_ONE;
                end
            end
        end else if (pop && !push) begin
            if (!empty) begin
                sp_d    = sp_q - PTR_ONE;
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            sp_q    <= sp_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter with opcode-driven next-PC selection, a return-address stack for
// CALL/RET, and sticky HALTED/FAULT states. Define PCU_RAS_WRAP_EN for a circular RAS.
module program_counter_unit
    import pcu_pkg::*;
#(
    parameter int              PC_W         = PCU_PC_W,
    parameter int              RAS_DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    localparam int             CNT_W        = $clog2(RAS_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [5:0]       opcode,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  pc_out,
    output logic [CNT_W-1:0] ras_count,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             halted,
    output logic             fault
);

`ifdef PCU_RAS_WRAP_EN
    localparam bit RAS_WRAP = 1'b1;
`else
    localparam bit RAS_WRAP = 1'b0;
`endif

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    pcu_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] ras_top;
    logic            ras_push, ras_pop;

    assign pc_inc = pc_q + PC_ONE;

    return_addr_stack #(
        .PC_W    (PC_W),
        .DEPTH   (RAS_DEPTH),
        .WRAP_EN (RAS_WRAP)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // enable is a plain advance qualifier: with it low nothing changes, and outside
    // RUN nothing changes either, so the stack is only touched from RUN.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (state_q == RUN && enable) begin
            case (opcode)
                OP_JMP:    pc_d = target;
                OP_BRANCH: pc_d = branch_taken ? target : pc_inc;
                OP_CALL: begin
                    if (ras_full && !RAS_WRAP) begin
                        state_d = FAULT;
                    end else begin
                        ras_push = 1'b1;
                        pc_d     = target;
                    end
                end
                OP_RET: begin
                    if (ras_empty) begin
                        state_d = FAULT;
                    end else begin
                        ras_pop = 1'b1;
                        pc_d    = ras_top;
                    end
                end
                OP_HALT:   state_d = HALTED;
                default:   pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_out = pc_q;
    assign halted = (state_q == HALTED);
    assign fault  = (state_q == FAULT);

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit; the overflow section follows PCU_RAS_WRAP_EN.
module tb_program_counter_unit;
    import pcu_pkg::*;

    localparam int PC_W  = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [5:0] OP_SEQ = 6'b000000;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [5:0]       opcode;
    logic             branch_taken;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc_out;
    logic [CNT_W-1:0] ras_count;
    logic             ras_full;
    logic             ras_empty;
    logic             halted;
    logic             fault;

    int checks;
    int errors;
    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] exp_pc;

    program_counter_unit #(
        .PC_W         (PC_W),
        .RAS_DEPTH    (DEPTH),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .target       (target),
        .pc_out       (pc_out),
        .ras_count    (ras_count),
        .ras_full     (ras_full),
        .ras_empty    (ras_empty),
        .halted       (halted),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one instruction, let one rising edge sample it, settle 1 time unit.
    task automatic step(input logic [5:0] op, input logic taken,
                        input logic [PC_W-1:0] tgt, input logic en);
        opcode       = op;
        branch_taken = taken;
        target       = tgt;
        enable       = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        enable = 1'b0;
        opcode = OP_SEQ;
        branch_taken = 1'b0;
        target = '0;
        #12;
        check("rst_pc", 32'(pc_out), 32'h0);
        check("rst_count", 32'(ras_count), 32'd0);
        check("rst_empty", 32'(ras_empty), 32'd1);
        check("rst_full", 32'(ras_full), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Sequential run, then asynchronous reset mid-cycle.
        for (int i = 1; i <= 3; i++) begin
            step(OP_SEQ, 1'b0, 16'h0000, 1'b1);
            check("seq_pc", 32'(pc_out), 32'(i));
        end
        step(OP_LOAD, 1'b0, 16'h0000, 1'b1);
        check("load_is_seq", 32'(pc_out), 32'h4);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_pc", 32'(pc_out), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Stall, jump, branch.
        step(OP_JMP, 1'b0, 16'h0005, 1'b1);
        check("jmp5_pc", 32'(pc_out), 32'h5);
        step(OP_JMP, 1'b0, 16'h0040, 1'b0);
        check("stall1_pc", 32'(pc_out), 32'h5);
        step(OP_CALL, 1'b0, 16'h0040, 1'b0);
        check("stall2_pc", 32'(pc_out), 32'h5);
        check("stall2_count", 32'(ras_count), 32'd0);
        step(OP_JMP, 1'b0, 16'h0040, 1'b1);
        check("jmp40_pc", 32'(pc_out), 32'h40);
        step(OP_BRANCH, 1'b0, 16'h0080, 1'b1);
        check("br_nt_pc", 32'(pc_out), 32'h41);
        step(OP_BRANCH, 1'b1, 16'h0080, 1'b1);
        check("br_t_pc", 32'(pc_out), 32'h80);
        step(OP_STORE, 1'b1, 16'h0500, 1'b1);
        check("store_is_seq", 32'(pc_out), 32'h81);

        // Nested CALL/RET.
        step(OP_JMP, 1'b0, 16'h0010, 1'b1);
        step(OP_CALL, 1'b0, 16'h0100, 1'b1);
        check("call1_pc", 32'(pc_out), 32'h100);
        check("call1_count", 32'(ras_count), 32'd1);
        step(OP_CALL, 1'b0, 16'h0200, 1'b1);
        check("call2_pc", 32'(pc_out), 32'h200);
        check("call2_count", 32'(ras_count), 32'd2);
        step(OP_RET, 1'b0, 16'h0000, 1'b1);
        check("ret1_pc", 32'(pc_out), 32'h101);
        check("ret1_count", 32'(ras_count), 32'd1);
        step(OP_RET, 1'b0, 16'h0000, 1'b1);
        check("ret2_pc", 32'(pc_out), 32'h11);
        check("ret2_count", 32'(ras_count), 32'd0);
        check("ret2_fault", 32'(fault), 32'd0);

        // RET on empty stack faults and sticks.
        do_reset();
        step(OP_RET, 1'b0, 16'h0000, 1'b1);
        check("uf_fault", 32'(fault), 32'd1);
        check("uf_pc", 32'(pc_out), 32'h0);
        check("uf_count", 32'(ras_count), 32'd0);
        step(OP_JMP, 1'b0, 16'h0055, 1'b1);
        check("uf_sticky_pc", 32'(pc_out), 32'h0);
        check("uf_sticky_fault", 32'(fault), 32'd1);

        // Fill the stack, then one more CALL.
        do_reset();
        exp_q.delete();
        exp_pc = 16'h0000;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(exp_pc + 16'h1);
            exp_pc = 16'h1000 + 16'(i * 16);
            step(OP_CALL, 1'b0, exp_pc, 1'b1);
        end
        check("fill_pc", 32'(pc_out), 32'h1070);
        check("fill_count", 32'(ras_count), 32'd8);
        check("fill_full", 32'(ras_full), 32'd1);
        step(OP_CALL, 1'b0, 16'h2000, 1'b1);
`ifdef PCU_RAS_WRAP_EN
        exp_q.push_back(16'h1071);
        void'(exp_q.pop_front());
        check("ovf_fault", 32'(fault), 32'd0);
        check("ovf_pc", 32'(pc_out), 32'h2000);
        check("ovf_count", 32'(ras_count), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            step(OP_RET, 1'b0, 16'h0000, 1'b1);
            check("wrap_ret_pc", 32'(pc_out), 32'(exp_q.pop_back()));
        end
        check("wrap_end_count", 32'(ras_count), 32'd0);
`else
        check("ovf_fault", 32'(fault), 32'd1);
        check("ovf_pc", 32'(pc_out), 32'h1070);
        check("ovf_count", 32'(ras_count), 32'd8);
`endif

        // Address wrap, CALL at the top of memory, HALT.
        do_reset();
        step(OP_JMP, 1'b0, 16'hFFFF, 1'b1);
        step(OP_SEQ, 1'b0, 16'h0000, 1'b1);
        check("wrap_seq_pc", 32'(pc_out), 32'h0);
        step(OP_JMP, 1'b0, 16'hFFFF, 1'b1);
        step(OP_CALL, 1'b0, 16'h0300, 1'b1);
        check("call_ffff_pc", 32'(pc_out), 32'h300);
        step(OP_RET, 1'b0, 16'h0000, 1'b1);
        check("ret_wrap_pc", 32'(pc_out), 32'h0);
        step(OP_JMP, 1'b0, 16'h0123, 1'b1);
        step(OP_HALT, 1'b0, 16'h0000, 1'b1);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc_out), 32'h123);
        for (int i = 0; i < 5; i++) begin
            step(OP_JMP, 1'b0, 16'($urandom_range(16'h0200, 16'hFFFE)), 1'b1);
            check("halt_frozen_pc", 32'(pc_out), 32'h123);
        end
        check("halt_still", 32'(halted), 32'd1);
        check("halt_no_fault", 32'(fault), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
